// File: rtl/ram_rd_stream.sv
// ram_rd_stream: valid/ready front-end for the read port of a 1R1W RAM with
// a one-cycle registered read. Requests become single-cycle RAM read pulses.
// Read data returns in request order on a backpressured response stream.
// A small circular FIFO catches words that arrive while the consumer stalls,
// and a credit check on issue guarantees that FIFO can never overflow.
`timescale 1ns/1ps

module ram_rd_stream #(
  parameter int DATA_WIDTH     = 4,
  parameter int SIZE           = 32,
  parameter int NUM_PARTITIONS = 1,
  parameter int ADDR_WIDTH     = $clog2(SIZE),
  parameter int FIFO_DEPTH     = 2
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [ADDR_WIDTH-1:0]     req_addr,
  input  logic [NUM_PARTITIONS-1:0] req_mask,
  input  logic                      req_valid,
  output logic                      req_ready,
  output logic [DATA_WIDTH-1:0]     resp_data,
  output logic                      resp_valid,
  input  logic                      resp_ready,
  output logic [ADDR_WIDTH-1:0]     ram_rd_addr,
  output logic                      ram_rd_en,
  output logic [NUM_PARTITIONS-1:0] ram_rd_mask,
  input  logic [DATA_WIDTH-1:0]     ram_rd_data,
  output logic                      busy
);

  localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CNT_W = $clog2(FIFO_DEPTH + 1);
  localparam logic [CNT_W-1:0] DEPTH_C  = CNT_W'(FIFO_DEPTH);
  localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(FIFO_DEPTH - 1);

  logic                  inflight_q, inflight_d;
  logic [CNT_W-1:0]      occ_q, occ_d;
  logic [PTR_W-1:0]      wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]      rd_ptr_q, rd_ptr_d;
  logic [DATA_WIDTH-1:0] fifo_q [FIFO_DEPTH];

  logic                  fifo_empty;
  logic                  push;
  logic                  pop;
  logic [CNT_W:0]        credits_used;

  // Circular pointer increment that wraps at FIFO_DEPTH, not at a power of two.
  function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
    return (p == LAST_PTR) ? '0 : p + PTR_W'(1);
  endfunction

  // Request path: issue only while a FIFO slot is guaranteed for the returning
  // word; gated by reset so no read is issued while the block is held in reset.
  always_comb begin
    credits_used = {1'b0, occ_q} + (CNT_W+1)'(inflight_q);
    req_ready    = rst & (credits_used < (CNT_W+1)'(FIFO_DEPTH));
    ram_rd_en    = req_valid & req_ready;
    ram_rd_addr  = req_addr;
    ram_rd_mask  = req_mask;
  end

  // Response path: FIFO head when buffered, otherwise bypass the RAM output.
  always_comb begin
    fifo_empty = (occ_q == '0);
    resp_valid = ~fifo_empty | inflight_q;
    resp_data  = fifo_empty ? ram_rd_data : fifo_q[rd_ptr_q];
    busy       = resp_valid;
    push       = inflight_q & ~(fifo_empty & resp_ready);
    pop        = ~fifo_empty & resp_ready;
  end

  // Next-state for occupancy, pointers and the in-flight flag.
  // NOTE: every output of an always_comb gets a default first so no path
  // leaves it unassigned and no latch is inferred.
  always_comb begin
    occ_d      = occ_q;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    inflight_d = ram_rd_en;
    if (push) wr_ptr_d = next_ptr(wr_ptr_q);
    if (pop)  rd_ptr_d = next_ptr(rd_ptr_q);
    case ({push, pop})
      2'b10:   occ_d = occ_q + CNT_W'(1);
      2'b01:   occ_d = occ_q - CNT_W'(1);
      default: occ_d = occ_q;
    endcase
  end

  // Control state register; reset discards anything in flight or buffered.
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge value of every other register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      inflight_q <= 1'b0;
      occ_q      <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
    end else begin
      inflight_q <= inflight_d;
      occ_q      <= occ_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
    end
  end

  // Response storage; writes the RAM word into the tail slot on a push.
  // NOTE: the data array has no reset; occ_q alone decides which entries are
  // meaningful, so clearing the storage would only cost reset fan-out.
  always_ff @(posedge clk) begin
    if (push) fifo_q[wr_ptr_q] <= ram_rd_data;
  end

  // The issue credit check must make a push into a full FIFO impossible.
  a_no_overflow : assert property (@(posedge clk) disable iff (!rst)
    !(push && (occ_q == DEPTH_C)));

endmodule
